dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the pipeline's MEM stage (EX/MEM address, store data and MemRead/MemWrite) and a slow off-chip data memory with 256-bit blocks.
- Answers hits combinationally without stalling.
- On a miss, asserts a stall that freezes the whole pipeline while an FSM writes back a dirty victim and refills the line.

---
 rtl/dcache_pkg.sv | 12 +
 rtl/dcache_sram.sv | 50 +++++
 rtl/dcache_ctrl.sv | 87 ++++++++
 tb/tb_dcache_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, address field positions and FSM states for the L1 data cache
package dcache_pkg;
  localparam int TAG_W = 22;
  localparam int INDEX_W = 5;
  localparam int OFFSET_W = 5;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WSEL_W = 3;
  localparam int WSEL_LSB = 2;
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_LSB = OFFSET_W + INDEX_W;
  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_FILL} state_e;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays, async read, sync line or word write
// Ports: idx_i selects the line for both read (valid_o/dirty_o/tag_o/data_o) and write;
// line_we_i installs a clean valid line, word_we_i merges one word and marks the line dirty.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    idx_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [BLOCK_BITS-1:0] data_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [BLOCK_BITS-1:0] line_data_i,
  input  logic                  word_we_i,
  input  logic [WSEL_W-1:0]     word_sel_i,
  input  logic [31:0]           word_data_i
);
  logic [NUM_LINES-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 data cache controller
// Ports: p1_* is the MEM-stage CPU side (combinational hit data, stall on miss);
// mem_* is the block-wide memory side (enable held until the one-cycle ack).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int BLOCK_BITS = 256,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     p1_addr_i,
  input  logic [31:0]           p1_data_i,
  input  logic                  p1_MemRead_i,
  input  logic                  p1_MemWrite_i,
  output logic [31:0]           p1_data_o,
  output logic                  p1_stall_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_data_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  input  logic [BLOCK_BITS-1:0] mem_data_i,
  input  logic                  mem_ack_i
);
  state_e                state_q, state_d;
  logic [BLOCK_BITS-1:0] fill_q, fill_d;
  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag, tag_rd;
  logic [WSEL_W-1:0]     wsel;
  logic                  valid_rd, dirty_rd, req, hit, idle;
  logic [BLOCK_BITS-1:0] data_rd;
  logic                  unused_addr;
  assign idx         = p1_addr_i[TAG_LSB-1:INDEX_LSB];
  assign tag         = p1_addr_i[ADDR_W-1:TAG_LSB];
  assign wsel        = p1_addr_i[INDEX_LSB-1:WSEL_LSB];
  assign unused_addr = ^p1_addr_i[WSEL_LSB-1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = req & valid_rd & (tag_rd == tag);
  assign idle        = state_q == S_IDLE;
  assign p1_stall_o  = (req & ~hit) | ~idle;
  assign p1_data_o   = (p1_MemRead_i & hit) ? data_rd[{wsel, 5'b0} +: 32] : 32'b0;
  dcache_sram #(.NUM_LINES(NUM_LINES), .BLOCK_BITS(BLOCK_BITS)) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .valid_o     (valid_rd),
    .dirty_o     (dirty_rd),
    .tag_o       (tag_rd),
    .data_o      (data_rd),
    .line_we_i   (state_q == S_FILL),
    .line_tag_i  (tag),
    .line_data_i (fill_q),
    .word_we_i   (idle & p1_MemWrite_i & hit),
    .word_sel_i  (wsel),
    .word_data_i (p1_data_i)
  );
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      S_IDLE: if (req & ~hit) state_d = (valid_rd & dirty_rd) ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_rd, idx, {OFFSET_W{1'b0}}};
        mem_data_o   = data_rd;
        state_d      = mem_ack_i ? S_ALLOCATE : S_WRITEBACK;
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, {OFFSET_W{1'b0}}};
        fill_d       = mem_ack_i ? mem_data_i : fill_q;
        state_d      = mem_ack_i ? S_FILL : S_ALLOCATE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    state_q <= rst_i ? S_IDLE : state_d;
    fill_q  <= fill_d;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized and directed checks of dcache_ctrl against a behavioural cache model
module tb_dcache_ctrl;
  logic         clk = 1'b0, rst = 1'b1;
  logic [31:0]  addr = '0, wdata = '0;
  logic         rd = 1'b0, wr = 1'b0;
  logic [31:0]  rdata, maddr;
  logic         stall, men, mwr;
  logic [255:0] mdata_o, mdata_i = '0;
  logic         ack_r = 1'b0, ack_inj = 1'b0, mack;
  int           checks = 0, failures = 0;
  int           lat = 4, cnt = 0;
  logic [255:0] ext_mem [int unsigned];
  logic [255:0] ref_mem [int unsigned];
  logic [31:0]  wb_addr_q[$], fill_addr_q[$];
  logic [255:0] wb_data_q[$];
  bit           ref_v [32], ref_d [32];
  logic [21:0]  ref_t [32];
  logic [255:0] ref_b [32];

  assign mack = ack_r | ack_inj;

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(addr), .p1_data_i(wdata),
    .p1_MemRead_i(rd), .p1_MemWrite_i(wr), .p1_data_o(rdata), .p1_stall_o(stall),
    .mem_addr_o(maddr), .mem_data_o(mdata_o), .mem_enable_o(men), .mem_write_o(mwr),
    .mem_data_i(mdata_i), .mem_ack_i(mack)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] init_blk(int unsigned b);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = (b * 8 + w) * 32'h01000193 ^ 32'hC0FFEE00;
    return r;
  endfunction

  function automatic logic [255:0] ext_rd(int unsigned b);
    return ext_mem.exists(b) ? ext_mem[b] : init_blk(b);
  endfunction

  function automatic logic [255:0] ref_rd(int unsigned b);
    return ref_mem.exists(b) ? ref_mem[b] : init_blk(b);
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory: acks in the lat-th cycle of each request, forgets a request when enable drops.
  always @(negedge clk) begin
    bit prev;
    prev  = ack_r;
    ack_r = 1'b0;
    if (!men) cnt = 0;
    else begin
      cnt = prev ? 1 : cnt + 1;
      if (cnt == lat) begin
        ack_r = 1'b1;
        if (mwr) begin
          ext_mem[maddr >> 5] = mdata_o;
          wb_addr_q.push_back(maddr);
          wb_data_q.push_back(mdata_o);
        end else begin
          mdata_i = ext_rd(maddr >> 5);
          fill_addr_q.push_back(maddr);
        end
      end
    end
  end

  task automatic do_op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    int           idx, ws, n;
    bit           hit, dv;
    logic [31:0]  exp_wb_addr;
    logic [255:0] exp_wb_data;
    idx = int'(a[9:5]);
    ws  = int'(a[4:2]);
    hit = ref_v[idx] && ref_t[idx] == a[31:10];
    dv  = ref_v[idx] && ref_d[idx];
    exp_wb_addr = {ref_t[idx], a[9:5], 5'b0};
    exp_wb_data = ref_b[idx];
    wb_addr_q.delete(); wb_data_q.delete(); fill_addr_q.delete();
    @(posedge clk); #1;
    addr = a; wdata = d; rd = r; wr = w;
    @(negedge clk);
    if (!hit) chk("miss_data_zero", rdata, 0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, hit ? 0 : (dv ? 2 * lat + 2 : lat + 2));
    chk("wb_count", wb_addr_q.size(), (!hit && dv) ? 1 : 0);
    if (wb_addr_q.size() > 0) begin
      chk("wb_addr", wb_addr_q[0], exp_wb_addr);
      chk("wb_data", wb_data_q[0], exp_wb_data);
    end
    chk("fill_count", fill_addr_q.size(), hit ? 0 : 1);
    if (fill_addr_q.size() > 0) chk("fill_addr", fill_addr_q[0], {a[31:5], 5'b0});
    if (!hit) begin
      if (dv) ref_mem[exp_wb_addr >> 5] = ref_b[idx];
      ref_b[idx] = ref_rd(a >> 5);
      ref_v[idx] = 1;
      ref_d[idx] = 0;
      ref_t[idx] = a[31:10];
    end
    if (w) begin
      ref_b[idx][ws*32 +: 32] = d;
      ref_d[idx] = 1;
    end else if (r) chk("rd_data", rdata, ref_b[idx][ws*32 +: 32]);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask

  initial begin
    int k;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_men", men, 0);
    chk("rst_mwr", mwr, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_rdata", rdata, 0);

    lat = 4;
    do_op(1, 0, 32'h400, 0);
    do_op(1, 0, 32'h404, 0);
    do_op(0, 1, 32'h408, 32'hDEADBEEF);
    do_op(1, 0, 32'h408, 0);
    do_op(1, 0, 32'h008, 0);
    chk("wb_word2_deadbeef", wb_data_q.size() > 0 ? wb_data_q[0][95:64] : 32'h0, 32'hDEADBEEF);
    do_op(0, 1, 32'h7E0, 32'h12345678);
    do_op(1, 0, 32'hBE0, 0);
    chk("idx31_wb_word0", wb_data_q.size() > 0 ? wb_data_q[0][31:0] : 32'h0, 32'h12345678);

    go_idle();
    ack_inj = 1;
    @(posedge clk); #1 ack_inj = 0;
    @(negedge clk);
    chk("idle_ack_stall", stall, 0);
    chk("idle_ack_men", men, 0);
    @(posedge clk); #1;
    addr = 32'hBE0; rd = 1; ack_inj = 1;
    @(negedge clk);
    chk("hit_ack_stall", stall, 0);
    chk("hit_ack_data", rdata, ref_b[31][31:0]);
    @(posedge clk); #1 ack_inj = 0;
    @(negedge clk);
    chk("hit_ack_stall2", stall, 0);
    chk("hit_ack_men", men, 0);

    go_idle();
    lat = 8;
    @(posedge clk); #1;
    addr = 32'h1000; rd = 1;
    k = 0;
    @(negedge clk);
    while (!(men && !mwr) && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("reached_allocate", men && !mwr, 1);
    @(posedge clk); #1;
    rst = 1; rd = 0;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 32; i++) begin
      ref_v[i] = 0;
      ref_d[i] = 0;
    end
    @(negedge clk);
    chk("midrst_stall", stall, 0);
    chk("midrst_men", men, 0);
    chk("midrst_mwr", mwr, 0);
    chk("midrst_maddr", maddr, 0);
    chk("midrst_mdata", mdata_o, 0);
    lat = 4;
    do_op(1, 0, 32'h1000, 0);

    for (int i = 0; i < 300; i++) begin
      int sel;
      bit r, w;
      lat = $urandom_range(1, 5);
      sel = $urandom_range(0, 3);
      a = '0;
      a[31:10] = 22'($urandom_range(0, 3));
      a[9:5] = sel == 0 ? 5'd0 : sel == 1 ? 5'd31 : sel == 2 ? 5'd1 : 5'($urandom_range(0, 31));
      a[4:2] = 3'($urandom_range(0, 7));
      w = $urandom_range(0, 2) == 0;
      r = !w || $urandom_range(0, 3) == 0;
      do_op(r, w, a, $urandom);
    end
    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
